icache_ctrl: RTL and testbench
==============================

// Module: icache_ctrl
// PURPOSE
//  Direct-mapped, read-only instruction cache and fetch sequencer between the IF stage and the memory controller's fetch port.
//  Serves IF hits from a local tag/data array; on a miss, drives one 4-byte fetch through the memory controller and refills the line.
//  Handles branch-mispredict abort and full flush, and keeps hit/miss counters for performance runs.
// PARAMETERS
//  INDEX_BITS  6   log2(line count); 1 line = 1 word (32 bits); tag = pc[31:INDEX_BITS+2]
// PORTS
//  clk            in   1   clock, all state updates on posedge
//  rst            in   1   synchronous, active-high reset
//  rdy            in   1   global ready; low = freeze every register, outputs hold
//  if_req         in   1   IF requests instruction at if_pc (sampled only in IDLE)
//  if_pc          in   32  fetch address; pc[1:0] ignored
//  if_abort       in   1   mispredict: discard pending/outstanding response
//  flush          in   1   invalidate all lines (fence.i)
//  if_ready       out  1   high in IDLE: a request is accepted this cycle
//  inst_valid     out  1   one-cycle pulse: inst is the word for the accepted if_pc
//  inst           out  32  instruction word
//  mem_fetch_en   out  1   to memory controller fetch_enable
//  mem_addr       out  32  to memory controller inst_addr, word aligned
//  mem_valid      in   1   from memory controller i_cache_valid (1-cycle pulse)
//  mem_data       in   32  from memory controller i_cache_data, valid with mem_valid
//  hit_cnt        out  32  saturating count of hits served
//  miss_cnt       out  32  saturating count of refills issued
// BEHAVIOUR
//  Reset: state=IDLE; all valid bits 0; inst_valid=0, inst=0, mem_fetch_en=0, mem_addr=0, hit_cnt=miss_cnt=0, aborted=0.
//  rdy=0: no register changes (mem_valid pulses arriving while rdy=0 are not captured; the memory controller freezes on the same rdy).
//  Lookup: idx=if_pc[INDEX_BITS+1:2]; hit = valid[idx] && tag[idx]==if_pc[31:INDEX_BITS+2].
//  inst_valid defaults to 0 every cycle: it is a 1-cycle pulse.
//  State IDLE (if_ready=1):
//   - if_abort=1 or flush=1: ignore if_req this cycle.
//   - if_req && hit: next cycle inst_valid=1, inst=data[idx]; hit_cnt++. Latency 1 cycle; back-to-back hits are accepted every cycle.
//   - if_req && miss: state->MISS; mem_fetch_en<=1; mem_addr<={if_pc[31:2],2'b00}; latch req idx/tag; miss_cnt++; aborted<=0.
//  State MISS (if_ready=0):
//   - mem_fetch_en held 1 until mem_valid is seen.
//   - if_abort=1: aborted<=1; refill continues.
//   - flush=1 (any cycle in MISS, incl. the mem_valid cycle): all valid bits cleared and killed<=1; the refill is not written.
//   - mem_valid=1: mem_fetch_en<=0, state->IDLE. Unless killed: valid[idx]<=1, tag/data written.
//     Unless aborted or if_abort in that cycle: next cycle inst_valid=1, inst=mem_data.
//   - Hit-path latency is 1 cycle; miss latency = memory controller fetch time + 1 cycle.
//   - mem_fetch_en is low the cycle after mem_valid, so the memory controller (in its post-transfer stall) never sees a spurious second request.
//  flush in IDLE: all valid bits cleared in 1 cycle; the same-cycle if_req is dropped. flush+if_abort together: both effects apply.
//  Counters: saturate at 32'hFFFF_FFFF and do not wrap; flush does not clear them; only rst does.
//  Aliasing: two PCs with equal idx evict each other; the last refill wins.
//  Reset mid-MISS: return to IDLE, drop mem_fetch_en the next cycle, no response; a later mem_valid in IDLE is ignored.
//  mem_valid while in IDLE: ignored.
// TESTING
//  1 Cold miss: rst, if_req pc=0x0000_1000, mem_valid+mem_data=0x0000_0013 after 6 cycles -> inst_valid 1 cycle later with 0x13, miss_cnt=1, mem_addr=0x1000.
//  2 Hit after refill: repeat pc=0x1000 -> inst_valid next cycle with 0x13, mem_fetch_en stays 0, hit_cnt=1; three back-to-back hits -> three consecutive pulses.
//  3 Conflict: pc=0x1000 then pc=0x1100 (same idx with INDEX_BITS=6) -> both miss, miss_cnt=2; pc=0x1000 again -> miss (evicted).
//  4 Abort: miss on 0x2000 with if_abort 2 cycles later -> no inst_valid; next req 0x2000 is a hit with the refilled data.
//  5 Flush: flush asserted during MISS for 0x3000 -> no line written, re-request misses; flush in IDLE after 0x1000 cached -> 0x1000 misses.
//  6 rdy low for 5 cycles while mem_valid is pending -> all outputs frozen, completion happens after rdy returns; rst mid-MISS -> IDLE, mem_fetch_en=0, counters 0.

Source files
------------

// File: rtl/icache_ctrl_if.sv
// Fetch-side (IF stage <-> cache) and memory-side (cache <-> memory controller) bundles
// for the direct-mapped instruction cache.
interface icache_fetch_if;
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_abort;
  logic        if_ready;
  logic        inst_valid;
  logic [31:0] inst;

  modport master (output if_req, output if_pc, output if_abort,
                  input  if_ready, input inst_valid, input inst);
  modport slave  (input  if_req, input if_pc, input if_abort,
                  output if_ready, output inst_valid, output inst);
endinterface

interface icache_mem_if;
  logic        mem_fetch_en;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;

  modport master (output mem_fetch_en, output mem_addr,
                  input  mem_valid, input mem_data);
  modport slave  (input  mem_fetch_en, input mem_addr,
                  output mem_valid, output mem_data);
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache: 1-cycle hits, single-word refill through
// the memory controller fetch port, with mispredict abort, full flush and perf counters.
module icache_ctrl #(
  parameter int INDEX_BITS = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  icache_fetch_if.slave     fetch,
  icache_mem_if.master      mem,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 32 - INDEX_BITS - 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MISS = 1'b1
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t                state_r;
  logic                  if_ready_r;
  logic                  inst_valid_r;
  logic [31:0]           inst_r;
  logic                  mem_fetch_en_r;
  logic [31:0]           mem_addr_r;
  logic [31:0]           hit_cnt_r;
  logic [31:0]           miss_cnt_r;
  logic                  aborted_r;
  logic                  killed_r;
  logic [INDEX_BITS-1:0] req_idx_r;
  logic [TAG_BITS-1:0]   req_tag_r;
  logic [LINES-1:0]      valid_r;
  logic [TAG_BITS-1:0]   tag_r  [LINES];
  logic [31:0]           data_r [LINES];

  logic [INDEX_BITS-1:0] lk_idx_s;
  logic [TAG_BITS-1:0]   lk_tag_s;
  logic                  hit_s;
  logic                  accept_s;
  logic                  refill_s;
  logic                  fill_we_s;
  logic                  unused_pc_s;

  assign lk_idx_s    = fetch.if_pc[INDEX_BITS+1:2];
  assign lk_tag_s    = fetch.if_pc[31:INDEX_BITS+2];
  assign unused_pc_s = ^fetch.if_pc[1:0];

  // Lookup and request qualification; abort/flush in IDLE drop the request.
  always_comb begin
    hit_s     = 1'b0;
    accept_s  = 1'b0;
    refill_s  = 1'b0;
    fill_we_s = 1'b0;
    if (state_r == ST_IDLE) begin
      hit_s    = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
      accept_s = fetch.if_req && !fetch.if_abort && !flush;
    end else begin
      refill_s  = mem.mem_valid;
      fill_we_s = mem.mem_valid && !killed_r && !flush;
    end
  end

  // Fetch sequencer: state, valid bits, response pulse, memory request and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      if_ready_r     <= 1'b1;
      inst_valid_r   <= 1'b0;
      inst_r         <= 32'd0;
      mem_fetch_en_r <= 1'b0;
      mem_addr_r     <= 32'd0;
      hit_cnt_r      <= 32'd0;
      miss_cnt_r     <= 32'd0;
      aborted_r      <= 1'b0;
      killed_r       <= 1'b0;
      req_idx_r      <= {INDEX_BITS{1'b0}};
      req_tag_r      <= {TAG_BITS{1'b0}};
      valid_r        <= {LINES{1'b0}};
    end else if (rdy) begin
      inst_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (flush) begin
            valid_r <= {LINES{1'b0}};
          end
          if (accept_s) begin
            if (hit_s) begin
              inst_valid_r <= 1'b1;
              inst_r       <= data_r[lk_idx_s];
              hit_cnt_r    <= sat_inc(hit_cnt_r);
            end else begin
              state_r        <= ST_MISS;
              if_ready_r     <= 1'b0;
              mem_fetch_en_r <= 1'b1;
              mem_addr_r     <= {fetch.if_pc[31:2], 2'b00};
              req_idx_r      <= lk_idx_s;
              req_tag_r      <= lk_tag_s;
              miss_cnt_r     <= sat_inc(miss_cnt_r);
              aborted_r      <= 1'b0;
              killed_r       <= 1'b0;
            end
          end
        end
        ST_MISS: begin
          if (fetch.if_abort) begin
            aborted_r <= 1'b1;
          end
          // A flush anywhere in the miss window kills the refill write but not the response.
          if (flush) begin
            valid_r  <= {LINES{1'b0}};
            killed_r <= 1'b1;
          end
          if (refill_s) begin
            state_r        <= ST_IDLE;
            if_ready_r     <= 1'b1;
            mem_fetch_en_r <= 1'b0;
            if (fill_we_s) begin
              valid_r[req_idx_r] <= 1'b1;
            end
            if (!aborted_r && !fetch.if_abort) begin
              inst_valid_r <= 1'b1;
              inst_r       <= mem.mem_data;
            end
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          if_ready_r     <= 1'b1;
          mem_fetch_en_r <= 1'b0;
        end
      endcase
    end
  end

  // Tag/data storage; contents are qualified by valid_r so they need no reset.
  always_ff @(posedge clk) begin
    if (!rst && rdy && fill_we_s) begin
      tag_r[req_idx_r]  <= req_tag_r;
      data_r[req_idx_r] <= mem.mem_data;
    end
  end

  assign fetch.if_ready   = if_ready_r;
  assign fetch.inst_valid = inst_valid_r;
  assign fetch.inst       = inst_r;
  assign mem.mem_fetch_en = mem_fetch_en_r;
  assign mem.mem_addr     = mem_addr_r;
  assign hit_cnt          = hit_cnt_r;
  assign miss_cnt         = miss_cnt_r;

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: cold miss, hits, conflicts, abort, flush, rdy freeze, reset.
module tb_icache_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic flush;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  int n_checks = 0;
  int n_fail = 0;

  icache_fetch_if fif ();
  icache_mem_if   mif ();

  icache_ctrl #(.INDEX_BITS(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .fetch(fif), .mem(mif),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request; afterwards outputs reflect the accept edge.
  task automatic do_req(input logic [31:0] pc);
    fif.if_req = 1'b1;
    fif.if_pc  = pc;
    cyc();
    fif.if_req = 1'b0;
  endtask

  // Memory returns data after 'gap' quiet cycles; afterwards outputs reflect the response edge.
  task automatic complete(input logic [31:0] data, input int gap);
    repeat (gap) cyc();
    mif.mem_valid = 1'b1;
    mif.mem_data  = data;
    cyc();
    mif.mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    fif.if_req = 1'b0; fif.if_pc = 32'd0; fif.if_abort = 1'b0;
    mif.mem_valid = 1'b0; mif.mem_data = 32'd0;
    cyc(); cyc();
    rst = 1'b0;
    n_checks++; if (fif.inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_inst_valid got=%0h exp=0", fif.inst_valid); end
    n_checks++; if (fif.inst !== 32'd0) begin n_fail++; $display("FAIL rst_inst got=%h exp=0", fif.inst); end
    n_checks++; if (mif.mem_fetch_en !== 1'b0 || mif.mem_addr !== 32'd0) begin n_fail++; $display("FAIL rst_mem got=%0h/%h exp=0/0", mif.mem_fetch_en, mif.mem_addr); end
    n_checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
    n_checks++; if (fif.if_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%0h exp=1", fif.if_ready); end
  endtask

  task automatic test_cold_miss();
    do_req(32'h0000_1000);
    n_checks++; if (mif.mem_fetch_en !== 1'b1 || mif.mem_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL cold_fetch got=%0h/%h exp=1/00001000", mif.mem_fetch_en, mif.mem_addr); end
    n_checks++; if (miss_cnt !== 32'd1 || fif.if_ready !== 1'b0) begin n_fail++; $display("FAIL cold_miss_cnt got=%0d/%0h exp=1/0", miss_cnt, fif.if_ready); end
    complete(32'h0000_0013, 5);
    n_checks++; if (fif.inst_valid !== 1'b1 || fif.inst !== 32'h0000_0013) begin n_fail++; $display("FAIL cold_resp got=%0h/%h exp=1/00000013", fif.inst_valid, fif.inst); end
    n_checks++; if (mif.mem_fetch_en !== 1'b0 || fif.if_ready !== 1'b1) begin n_fail++; $display("FAIL cold_release got=%0h/%0h exp=0/1", mif.mem_fetch_en, fif.if_ready); end
    cyc();
    n_checks++; if (fif.inst_valid !== 1'b0) begin n_fail++; $display("FAIL cold_pulse got=%0h exp=0", fif.inst_valid); end
  endtask

  task automatic test_hit();
    do_req(32'h0000_1000);
    n_checks++; if (fif.inst_valid !== 1'b1 || fif.inst !== 32'h0000_0013) begin n_fail++; $display("FAIL hit_resp got=%0h/%h exp=1/00000013", fif.inst_valid, fif.inst); end
    n_checks++; if (mif.mem_fetch_en !== 1'b0 || hit_cnt !== 32'd1) begin n_fail++; $display("FAIL hit_cnt got=%0h/%0d exp=0/1", mif.mem_fetch_en, hit_cnt); end
  endtask

  task automatic test_back_to_back();
    fif.if_req = 1'b1;
    fif.if_pc  = 32'h0000_1000;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++; if (fif.inst_valid !== 1'b1 || fif.inst !== 32'h0000_0013) begin n_fail++; $display("FAIL b2b_%0d got=%0h/%h exp=1/00000013", i, fif.inst_valid, fif.inst); end
    end
    fif.if_req = 1'b0;
    cyc();
    n_checks++; if (hit_cnt !== 32'd4 || fif.inst_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_cnt got=%0d/%0h exp=4/0", hit_cnt, fif.inst_valid); end
  endtask

  task automatic test_conflict();
    do_req(32'h0000_1100);
    n_checks++; if (mif.mem_fetch_en !== 1'b1 || mif.mem_addr !== 32'h0000_1100) begin n_fail++; $display("FAIL conf_miss got=%0h/%h exp=1/00001100", mif.mem_fetch_en, mif.mem_addr); end
    complete(32'h0000_00AA, 2);
    n_checks++; if (fif.inst !== 32'h0000_00AA || miss_cnt !== 32'd2) begin n_fail++; $display("FAIL conf_fill got=%h/%0d exp=000000aa/2", fif.inst, miss_cnt); end
    cyc();
    do_req(32'h0000_1000);
    n_checks++; if (mif.mem_fetch_en !== 1'b1 || fif.inst_valid !== 1'b0 || miss_cnt !== 32'd3) begin n_fail++; $display("FAIL conf_evict got=%0h/%0h/%0d exp=1/0/3", mif.mem_fetch_en, fif.inst_valid, miss_cnt); end
    complete(32'h0000_0013, 1);
    cyc();
  endtask

  task automatic test_abort();
    do_req(32'h0000_2000);
    cyc();
    fif.if_abort = 1'b1;
    cyc();
    fif.if_abort = 1'b0;
    n_checks++; if (mif.mem_fetch_en !== 1'b1) begin n_fail++; $display("FAIL abort_keep got=%0h exp=1", mif.mem_fetch_en); end
    complete(32'h0000_BEEF, 3);
    n_checks++; if (fif.inst_valid !== 1'b0 || mif.mem_fetch_en !== 1'b0) begin n_fail++; $display("FAIL abort_resp got=%0h/%0h exp=0/0", fif.inst_valid, mif.mem_fetch_en); end
    do_req(32'h0000_2000);
    n_checks++; if (fif.inst_valid !== 1'b1 || fif.inst !== 32'h0000_BEEF || hit_cnt !== 32'd5) begin n_fail++; $display("FAIL abort_hit got=%0h/%h/%0d exp=1/0000beef/5", fif.inst_valid, fif.inst, hit_cnt); end
  endtask

  task automatic test_flush();
    do_req(32'h0000_3000);
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    complete(32'h0000_3333, 2);
    n_checks++; if (fif.inst_valid !== 1'b1 || fif.inst !== 32'h0000_3333) begin n_fail++; $display("FAIL flush_resp got=%0h/%h exp=1/00003333", fif.inst_valid, fif.inst); end
    do_req(32'h0000_3000);
    n_checks++; if (mif.mem_fetch_en !== 1'b1 || miss_cnt !== 32'd6) begin n_fail++; $display("FAIL flush_nofill got=%0h/%0d exp=1/6", mif.mem_fetch_en, miss_cnt); end
    complete(32'h0000_3333, 1);
    do_req(32'h0000_3000);
    n_checks++; if (fif.inst_valid !== 1'b1 || hit_cnt !== 32'd6) begin n_fail++; $display("FAIL flush_refill_hit got=%0h/%0d exp=1/6", fif.inst_valid, hit_cnt); end
    do_req(32'h0000_1000);
    complete(32'h0000_0013, 1);
    do_req(32'h0000_1000);
    n_checks++; if (fif.inst_valid !== 1'b1 || hit_cnt !== 32'd7) begin n_fail++; $display("FAIL flush_pre_hit got=%0h/%0d exp=1/7", fif.inst_valid, hit_cnt); end
    // flush with a same-cycle request: request dropped, line invalidated
    flush = 1'b1;
    do_req(32'h0000_1000);
    flush = 1'b0;
    n_checks++; if (fif.inst_valid !== 1'b0 || mif.mem_fetch_en !== 1'b0 || fif.if_ready !== 1'b1) begin n_fail++; $display("FAIL flush_drop got=%0h/%0h/%0h exp=0/0/1", fif.inst_valid, mif.mem_fetch_en, fif.if_ready); end
    do_req(32'h0000_1000);
    n_checks++; if (mif.mem_fetch_en !== 1'b1 || miss_cnt !== 32'd8 || hit_cnt !== 32'd7) begin n_fail++; $display("FAIL flush_idle_miss got=%0h/%0d/%0d exp=1/8/7", mif.mem_fetch_en, miss_cnt, hit_cnt); end
    complete(32'h0000_0013, 1);
    cyc();
  endtask

  task automatic test_rdy_freeze();
    do_req(32'h0000_4000);
    rdy = 1'b0;
    mif.mem_valid = 1'b1;
    mif.mem_data  = 32'h0000_4444;
    cyc();
    mif.mem_valid = 1'b0;
    repeat (4) cyc();
    n_checks++; if (mif.mem_fetch_en !== 1'b1 || mif.mem_addr !== 32'h0000_4000 || fif.if_ready !== 1'b0) begin n_fail++; $display("FAIL freeze_mem got=%0h/%h/%0h exp=1/00004000/0", mif.mem_fetch_en, mif.mem_addr, fif.if_ready); end
    n_checks++; if (fif.inst_valid !== 1'b0 || fif.inst !== 32'h0000_0013 || miss_cnt !== 32'd9) begin n_fail++; $display("FAIL freeze_out got=%0h/%h/%0d exp=0/00000013/9", fif.inst_valid, fif.inst, miss_cnt); end
    rdy = 1'b1;
    complete(32'h0000_4444, 1);
    n_checks++; if (fif.inst_valid !== 1'b1 || fif.inst !== 32'h0000_4444 || mif.mem_fetch_en !== 1'b0) begin n_fail++; $display("FAIL freeze_done got=%0h/%h/%0h exp=1/00004444/0", fif.inst_valid, fif.inst, mif.mem_fetch_en); end
    cyc();
  endtask

  task automatic test_reset_mid_miss();
    do_req(32'h0000_5000);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_checks++; if (mif.mem_fetch_en !== 1'b0 || fif.if_ready !== 1'b1 || hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin n_fail++; $display("FAIL rstmiss got=%0h/%0h/%0d/%0d exp=0/1/0/0", mif.mem_fetch_en, fif.if_ready, hit_cnt, miss_cnt); end
    complete(32'h0000_5555, 1);
    n_checks++; if (fif.inst_valid !== 1'b0 || fif.inst !== 32'd0) begin n_fail++; $display("FAIL rstmiss_late got=%0h/%h exp=0/0", fif.inst_valid, fif.inst); end
    do_req(32'h0000_1000);
    n_checks++; if (mif.mem_fetch_en !== 1'b1 || fif.inst_valid !== 1'b0 || miss_cnt !== 32'd1) begin n_fail++; $display("FAIL rstmiss_cold got=%0h/%0h/%0d exp=1/0/1", mif.mem_fetch_en, fif.inst_valid, miss_cnt); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_back_to_back();
    test_conflict();
    test_abort();
    test_flush();
    test_rdy_freeze();
    test_reset_mid_miss();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
